// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider / tick generator; optional forced-wrap input sync via CLKDIV_SYNC_EN
module clk_div_gen #(
  parameter int WIDTH = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_pending,
  output logic [WIDTH-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'((DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV);
  logic [WIDTH-1:0] cnt, pend, cnt_next, div_next, div_clamped;
  logic [WIDTH:0] h_next;
  logic wrap;
  // next-phase computation; a wrap swaps in the pending divisor before the outputs are derived
  always_comb begin
`ifdef CLKDIV_SYNC_EN
    wrap = (cnt == div_active - WIDTH'(1)) || sync;
`else
    wrap = (cnt == div_active - WIDTH'(1));
`endif
    div_next = (wrap && div_pending) ? pend : div_active;
    cnt_next = wrap ? '0 : cnt + WIDTH'(1);
    h_next = ({1'b0, div_next} + (WIDTH+1)'(1)) >> 1;
    div_clamped = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
  end
  // phase counter, divisor hand-over and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= DEF - WIDTH'(1);
      div_active <= DEF;
      pend <= '0;
      div_pending <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      if (en) begin
        cnt <= cnt_next;
        div_active <= div_next;
        clk_out <= {1'b0, cnt_next} < h_next;
      end
      tick <= en && wrap;
      pend <= div_load ? div_clamped : pend;
      div_pending <= div_load || (div_pending && !(en && wrap));
    end
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen
module tb_clk_div_gen;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic div_pending, clk_out, tick;
  logic [15:0] div_active;
  int n_cmp = 0, n_bad = 0;
`ifdef CLKDIV_SYNC_EN
  logic sync = 1'b0;
`endif

  clk_div_gen #(.WIDTH(16), .DEFAULT_DIV(2)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .div_in(div_in),
    .div_load(div_load),
`ifdef CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .div_pending(div_pending),
    .div_active(div_active),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    div_in = v;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_clk, exp_tick;
    exp_clk = 5'b10011;
    exp_tick = 5'b10000;
    step();
    chk("rst_active", div_active, 2);
    chk("rst_pending", div_pending, 0);
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    reset = 1'b0;
    en = 1'b1;
    step();
    chk("d2_first_tick", tick, 1);
    chk("d2_first_clk", clk_out, 1);
    step();
    chk("d2_tick1", tick, 0);
    chk("d2_clk1", clk_out, 0);
    step();
    chk("d2_tick2", tick, 1);
    chk("d2_clk2", clk_out, 1);
    load(16'd5);
    chk("d5_pending", div_pending, 1);
    chk("d5_still2", div_active, 2);
    step();
    chk("d5_active", div_active, 5);
    chk("d5_pending_clr", div_pending, 0);
    chk("d5_wrap_tick", tick, 1);
    chk("d5_wrap_clk", clk_out, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("d5_clk_seq", clk_out, exp_clk[i]);
      chk("d5_tick_seq", tick, exp_tick[i]);
    end
    load(16'd0);
    load(16'd1);
    chk("clamp_pending", div_pending, 1);
    step();
    step();
    chk("clamp_before", div_active, 5);
    step();
    chk("clamp_active", div_active, 2);
    chk("clamp_tick", tick, 1);
    chk("clamp_pending_clr", div_pending, 0);
    load(16'd4);
    load(16'd6);
    chk("sim_active4", div_active, 4);
    chk("sim_pending", div_pending, 1);
    chk("sim_tick", tick, 1);
    for (int i = 0; i < 3; i++) step();
    chk("sim_still4", div_active, 4);
    chk("sim_notick", tick, 0);
    step();
    chk("sim_active6", div_active, 6);
    chk("sim_tick6", tick, 1);
    chk("sim_pending_clr", div_pending, 0);
    load(16'd8);
    for (int i = 0; i < 5; i++) step();
    chk("d8_active", div_active, 8);
    chk("d8_tick", tick, 1);
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_tick", tick, 0);
      chk("frz_clk", clk_out, 1);
    end
    en = 1'b1;
    step();
    chk("res_cnt3_clk", clk_out, 1);
    step();
    chk("res_cnt4_clk", clk_out, 0);
    step();
    step();
    step();
    chk("res_cnt7_tick", tick, 0);
    step();
    chk("res_wrap_tick", tick, 1);
    chk("res_wrap_clk", clk_out, 1);
    load(16'd7);
    for (int i = 0; i < 7; i++) step();
    chk("d7_active", div_active, 7);
    load(16'd9);
    chk("d9_pending", div_pending, 1);
    reset = 1'b1;
    step();
    chk("mrst_active", div_active, 2);
    chk("mrst_pending", div_pending, 0);
    chk("mrst_clk", clk_out, 0);
    chk("mrst_tick", tick, 0);
    reset = 1'b0;
    step();
    chk("mrst_first_tick", tick, 1);
    step();
    step();
    chk("mrst_discard", div_active, 2);
    chk("mrst_discard_p", div_pending, 0);
`ifdef CLKDIV_SYNC_EN
    load(16'd6);
    step();
    chk("sy_active6", div_active, 6);
    step();
    step();
    step();
    chk("sy_cnt3_clk", clk_out, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sy_tick", tick, 1);
    chk("sy_clk", clk_out, 1);
    step();
    step();
    en = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    en = 1'b1;
    chk("sy_ign_tick", tick, 0);
    chk("sy_ign_clk", clk_out, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised, runtime-programmable clock divider and tick generator. Generalises the fixed divide-by-2 clock generator.
- Produces a divided level output `clk_out` (50% duty for even divisors, high-biased for odd) and a one-cycle `tick` strobe at each period start. Both are intended as clock-enables for game-logic and display timing in the `clk` domain.
- Divisor changes are glitch-free: a new value is held pending and applied only at a period boundary.

Parameters:
- WIDTH, 16, width of divisor and phase counter.
- DEFAULT_DIV, 2, divisor in effect after reset. Values below 2 are clamped to 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; when 0, phase counter and `clk_out` hold.
- div_in  input  WIDTH  requested divisor D.
- div_load  input  1  1-cycle strobe; captures `div_in` into the pending register.
- div_pending  output  1  high while a captured divisor is awaiting a period boundary.
- div_active  output  WIDTH  divisor currently in effect (post-clamp).
- clk_out  output  1  divided clock level (registered).
- tick  output  1  one-cycle strobe marking cnt==0 (registered).

Behaviour:
- Clamp rule: Deff = (D<2) ? 2 : D. Clamping is applied at capture time. High half H = (Deff+1)>>1, i.e. ceil.
- Reset state:
  - cnt = clamp(DEFAULT_DIV)-1, the "last phase", so the first enabled edge wraps.
  - div_active = clamp(DEFAULT_DIV); pending register = 0; div_pending = 0.
  - clk_out = 0; tick = 0.
- Each posedge with en=1:
  - If cnt == div_active-1: wrap. cnt<=0. If div_pending=1, div_active<=pending and div_pending<=0.
  - Otherwise cnt<=cnt+1.
  - Registered outputs follow the new cnt and the new div_active in the same edge:
    - clk_out <= (cnt_next < H_next).
    - tick <= (cnt_next == 0).
- Each posedge with en=0: cnt, div_active and clk_out hold; tick<=0. Disabling mid-period freezes the phase; re-enabling resumes from the frozen phase.
- div_load:
  - On an edge with div_load=1: pending<=clamp(div_in) and div_pending<=1.
  - Loads accepted regardless of en.
  - Multiple loads before a boundary: last value wins.
- Simultaneous load and wrap on the same edge: the wrap applies the previously pending value (if any). The newly loaded value stays pending (div_pending=1) and applies at the next wrap.
- Latency: for a load while idle-pending, the new divisor takes effect at the first wrap after capture. The first tick of the new period is the first cycle using the new value.
- Period: with en held 1, tick asserts once every Deff cycles. clk_out is high H cycles, then low Deff-H cycles.
- Counter arithmetic is WIDTH bits unsigned. The maximum divisor is 2^WIDTH-1; cnt never exceeds Deff-1, so it never overflows.
- Reset mid-operation: all state returns to reset values on that edge, and any pending divisor is discarded. Reset has priority over en, div_load and sync.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- When defined:
  - Adds input port `sync` (1 bit).
  - On an edge with sync=1 and en=1, a wrap is forced regardless of cnt: cnt<=0, tick<=1, clk_out<=1, and the pending divisor is applied if present.
  - sync with en=0 is ignored.
  - Used to phase-align multiple dividers.
- When undefined: the port is absent and there is no forced-wrap logic. Behaviour is exactly as above.

Test Plan:
- Reset, DEFAULT_DIV=2, en=1 -> first edge tick=1 and clk_out=1; then clk_out toggles every cycle (100 MHz in -> 50 MHz out); tick every 2nd cycle.
- Load div_in=5 mid-period -> div_pending=1 until the next wrap. Then div_active=5, and clk_out is high 3 / low 2 cycles. tick every 5 cycles.
- Load div_in=0 and div_in=1 -> div_active becomes 2 after the boundary (clamp).
- div_load on the same edge as a wrap with value 4 pending and new value 6 -> the wrap applies 4; div_pending stays 1; 6 applies one period (4 cycles) later.
- en deasserted at cnt=2 of a divide-by-8 period for 10 cycles -> clk_out and cnt frozen and tick=0. On resume, the period completes after the remaining 5 enabled cycles.
- Reset asserted with a pending value 9 and D=7 running -> after reset: div_active=2, div_pending=0, clk_out=0. With CLKDIV_SYNC_EN, sync=1 at cnt=3 of a D=6 period -> tick=1 and clk_out=1 on the next edge.
